sal_ref_ctrl: RTL and testbench
===============================

SAL_REF_CTRL -- requirements
Module: sal_ref_ctrl

Interface
REQ-001 Parameters SHALL be:
- BK_CNT, default 16, bank count.
- REFI_W, default 16, tREFI counter width.
- RFC_W, default 10, tRFC counter width.
- MAX_PEND, default 8, maximum postponed refreshes.

REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.

REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- ref_en_i, in, 1, refresh enable.
- t_refi_m1_i, in, REFI_W, tREFI-1 in cycles.
- t_rfc_m1_i, in, RFC_W, tRFC-1 in cycles.
- urgent_thr_i, in, 4, pending count that forces refresh (1..MAX_PEND).
- bk_idle_arr_i, in, BK_CNT, per-bank: precharged and tRP met.
- bk_req_any_i, in, 1, any bank controller holds a queued request.
- ref_block_o, out, 1, bank controllers SHALL NOT activate; they close open rows.
- ref_req_o, out, 1, all-bank REF request to the scheduler.
- ref_gnt_i, in, 1, scheduler grant for REF (single-cycle).
- ref_done_o, out, 1, one-cycle pulse at end of tRFC.
- pend_cnt_o, out, 4, postponed-refresh count.
- pend_ovf_o, out, 1, sticky overflow flag.

Function
REQ-004 The tREFI down-counter SHALL decrement each cycle while ref_en_i=1, produce a tick when it is 0, and reload t_refi_m1_i on the tick cycle.
REQ-005 While ref_en_i=0, the tREFI counter SHALL hold at t_refi_m1_i and no ticks SHALL occur.
REQ-006 A tick SHALL increment pend_cnt_o on the next cycle.
REQ-007 A ref_gnt_i SHALL decrement pend_cnt_o on the next cycle.
REQ-008 A tick and a ref_gnt_i in the same cycle SHALL leave pend_cnt_o unchanged.
REQ-009 pend_cnt_o SHALL saturate at MAX_PEND; a tick (without simultaneous grant) at MAX_PEND SHALL set pend_ovf_o, which stays set until rst.
REQ-010 The FSM SHALL have the states IDLE, DRAIN, REQ and RFC.
REQ-011 IDLE->REQ (opportunistic) SHALL occur when pend_cnt_o>0, &bk_idle_arr_i=1 and bk_req_any_i=0.
REQ-012 IDLE->DRAIN (urgent) SHALL occur when pend_cnt_o>=urgent_thr_i and the REQ-011 condition is false.
REQ-013 DRAIN->REQ SHALL occur when &bk_idle_arr_i=1.
REQ-014 REQ->RFC SHALL occur on ref_gnt_i=1; the tRFC counter SHALL load t_rfc_m1_i in the same cycle.
REQ-015 In RFC the tRFC counter SHALL decrement each cycle; when it is 0, ref_done_o=1 that cycle and the next state SHALL be IDLE.
REQ-016 ref_block_o SHALL be 1 in DRAIN, REQ and RFC, and 0 in IDLE.
REQ-017 ref_req_o SHALL be 1 only in REQ; it SHALL be a Moore output and remain held until ref_gnt_i.
REQ-018 ref_gnt_i outside REQ SHALL be ignored and SHALL NOT change pend_cnt_o.
REQ-019 Timing: with ref_gnt_i at cycle N, RFC SHALL occupy cycles N+1..N+t_rfc_m1_i+1, ref_done_o SHALL pulse at N+t_rfc_m1_i+1, and ref_block_o SHALL fall at N+t_rfc_m1_i+2.
REQ-020 If ref_en_i drops mid-sequence, the sequence in progress SHALL complete; pending refreshes SHALL still be serviced.
REQ-021 If the bk_idle_arr_i condition drops while in REQ, ref_req_o SHALL stay asserted; the scheduler is responsible for gating.
REQ-022 t_refi_m1_i, t_rfc_m1_i and urgent_thr_i SHALL be sampled live; changes SHALL take effect at the next reload or compare.

Reset
REQ-023 On rst=1, the FSM SHALL go to IDLE.
REQ-024 On rst=1, pend_cnt_o, pend_ovf_o, ref_block_o, ref_req_o and ref_done_o SHALL be 0.
REQ-025 On rst=1, the tREFI counter SHALL load t_refi_m1_i and the tRFC counter SHALL be 0.
REQ-026 Reset asserted in any state SHALL abort the sequence in progress and apply REQ-023..REQ-025 on the next edge.

Verification
REQ-027 Opportunistic refresh:
- stimulus: t_refi_m1_i=99, ref_en_i=1 from reset release (cycle 0), all banks idle, bk_req_any_i=0, ref_gnt_i answered 1 cycle after ref_req_o.
- required: pend_cnt_o=1 at cycle 100, ref_req_o=1 at cycle 101, pend_cnt_o back to 0 after the grant.
REQ-028 Urgent drain:
- stimulus: urgent_thr_i=2, bk_req_any_i=1, bk_idle_arr_i=0 until 5 cycles after the second tick.
- required: ref_block_o=1 the cycle after pend_cnt_o=2; ref_req_o stays 0 until all banks are idle, then asserts the next cycle.
REQ-029 tRFC timing:
- stimulus: t_rfc_m1_i=9, grant at cycle N.
- required: ref_done_o=1 only at N+10; ref_block_o=0 at N+11.
REQ-030 Saturation and overflow:
- stimulus: ref_gnt_i held 0, 9 ticks.
- required: pend_cnt_o=8 and pend_ovf_o=1 after the 9th tick; pend_ovf_o persists after later grants.
REQ-031 Simultaneous events:
- stimulus: tick coincides with ref_gnt_i at pend_cnt_o=3.
- required: pend_cnt_o=3 the next cycle; also, ref_gnt_i pulsed in IDLE leaves pend_cnt_o unchanged.
REQ-032 Reset mid-RFC:
- stimulus: rst pulsed at N+4 of a t_rfc_m1_i=9 sequence.
- required: the next cycle shows all outputs 0, state IDLE, and no ref_done_o pulse.

Source files
------------

// File: rtl/sal_ref_ctrl_if.sv
// Refresh controller <-> scheduler / bank-controller handshake bundle.
interface sal_ref_ctrl_if #(parameter int BK_CNT = 16);
  logic              ref_block_o;
  logic              ref_req_o;
  logic              ref_done_o;
  logic              ref_gnt_i;
  logic [BK_CNT-1:0] bk_idle_arr_i;
  logic              bk_req_any_i;

  modport master (
    output ref_block_o, ref_req_o, ref_done_o,
    input  ref_gnt_i, bk_idle_arr_i, bk_req_any_i
  );

  modport slave (
    input  ref_block_o, ref_req_o, ref_done_o,
    output ref_gnt_i, bk_idle_arr_i, bk_req_any_i
  );
endinterface

// File: rtl/sal_ref_ctrl.sv
// All-bank refresh controller: tREFI tick generation, postponed-refresh
// accounting, opportunistic/urgent refresh sequencing and tRFC timing.
module sal_ref_ctrl #(
  parameter int BK_CNT   = 16,
  parameter int REFI_W   = 16,
  parameter int RFC_W    = 10,
  parameter int MAX_PEND = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_en_i,
  input  logic [REFI_W-1:0] t_refi_m1_i,
  input  logic [RFC_W-1:0]  t_rfc_m1_i,
  input  logic [3:0]        urgent_thr_i,
  sal_ref_ctrl_if.master    bus,
  output logic [3:0]        pend_cnt_o,
  output logic              pend_ovf_o
);
  localparam logic [3:0] MAX_P = 4'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, DRAIN, REQ, RFC} state_e;

  state_e            state_q, state_d;
  logic [REFI_W-1:0] refi_q, refi_d;
  logic [RFC_W-1:0]  rfc_q, rfc_d;
  logic [3:0]        pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              done;
  logic              tick, gnt_ok, all_idle, opp;
  logic [BK_CNT-1:0] idle_w;

  assign idle_w = bus.bk_idle_arr_i;

  always_comb begin
    tick     = ref_en_i && (refi_q == '0);
    gnt_ok   = bus.ref_gnt_i && (state_q == REQ);
    all_idle = &idle_w;
    opp      = (pend_q != 4'd0) && all_idle && !bus.bk_req_any_i;

    refi_d = (!ref_en_i || tick) ? t_refi_m1_i : refi_q - 1'b1;

    // Tick and grant in the same cycle cancel out.
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (tick && !gnt_ok) begin
      if (pend_q >= MAX_P) ovf_d = 1'b1;
      else                 pend_d = pend_q + 4'd1;
    end else if (gnt_ok && !tick && pend_q != 4'd0) begin
      pend_d = pend_q - 4'd1;
    end

    state_d = state_q;
    rfc_d   = rfc_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (opp)                          state_d = REQ;
        else if (pend_q >= urgent_thr_i)  state_d = DRAIN;
      end
      DRAIN: if (all_idle) state_d = REQ;
      // Request stays up even if banks reopen; the scheduler gates the grant.
      REQ: if (bus.ref_gnt_i) begin
        state_d = RFC;
        rfc_d   = t_rfc_m1_i;
      end
      RFC: begin
        if (rfc_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          rfc_d = rfc_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      refi_q  <= t_refi_m1_i;
      rfc_q   <= '0;
      pend_q  <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      refi_q  <= refi_d;
      rfc_q   <= rfc_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ref_block_o = (state_q != IDLE);
  assign bus.ref_req_o   = (state_q == REQ);
  assign bus.ref_done_o  = done;
  assign pend_cnt_o      = pend_q;
  assign pend_ovf_o      = ovf_q;
endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Bench for sal_ref_ctrl: directed scenarios plus a randomized run, all
// checked each cycle against a cycle-numbered behavioural model.
module tb_sal_ref_ctrl;
  localparam int MAXP = 8;
  localparam int PH_IDLE = 0, PH_DRAIN = 1, PH_REQ = 2, PH_RFC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] t_refi;
  logic [9:0]  t_rfc;
  logic [3:0]  thr;
  logic [3:0]  pend;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  // model state: absolute cycle numbers rather than counters for tRFC
  int m_cyc, m_left, m_pend, m_ph, m_done_at, m_req_age;
  bit m_ovf;
  bit auto_gnt;

  sal_ref_ctrl_if #(.BK_CNT(16)) ifc ();

  sal_ref_ctrl #(.BK_CNT(16), .REFI_W(16), .RFC_W(10), .MAX_PEND(MAXP)) dut (
    .clk          (clk),
    .rst          (rst),
    .ref_en_i     (en),
    .t_refi_m1_i  (t_refi),
    .t_rfc_m1_i   (t_rfc),
    .urgent_thr_i (thr),
    .bus          (ifc.master),
    .pend_cnt_o   (pend),
    .pend_ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, m_cyc, act, exp);
    end
  endtask

  // Applies the rules for one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit tick, gr;
    int p;
    if (rst) begin
      m_left = int'(t_refi); m_pend = 0; m_ovf = 1'b0; m_ph = PH_IDLE; m_cyc = 0;
      return;
    end
    tick = en && (m_left == 0);
    gr   = (m_ph == PH_REQ) && ifc.ref_gnt_i;
    p = m_pend + int'(tick) - int'(gr);
    if (p > MAXP) begin p = MAXP; m_ovf = 1'b1; end
    if (p < 0) p = 0;
    case (m_ph)
      PH_IDLE:
        if (m_pend > 0 && (&ifc.bk_idle_arr_i) && !ifc.bk_req_any_i) m_ph = PH_REQ;
        else if (m_pend >= int'(thr)) m_ph = PH_DRAIN;
      PH_DRAIN: if (&ifc.bk_idle_arr_i) m_ph = PH_REQ;
      PH_REQ: if (ifc.ref_gnt_i) begin m_ph = PH_RFC; m_done_at = m_cyc + int'(t_rfc) + 1; end
      default: if (m_cyc == m_done_at) m_ph = PH_IDLE;
    endcase
    m_pend = p;
    m_left = (!en || m_left == 0) ? int'(t_refi) : m_left - 1;
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (m_ph == PH_REQ) m_req_age++; else m_req_age = 0;
    chk("ref_block", 16'(ifc.ref_block_o), 16'(m_ph != PH_IDLE));
    chk("ref_req",   16'(ifc.ref_req_o),   16'(m_ph == PH_REQ));
    chk("ref_done",  16'(ifc.ref_done_o),  16'(m_ph == PH_RFC && m_cyc == m_done_at));
    chk("pend_cnt",  16'(pend),            16'(m_pend));
    chk("pend_ovf",  16'(ovf),             16'(m_ovf));
    if (auto_gnt) ifc.ref_gnt_i = (m_req_age == 2);
  endtask

  task automatic run_to(input int n);
    int g = 0;
    while (m_cyc < n && g < 2000) begin step(); g++; end
    if (g >= 2000) begin
      fails++;
      $error("FAIL run_to cyc=%0d got=%0d exp=%0d", m_cyc, m_cyc, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ifc.ref_gnt_i = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; t_refi = 16'd99; t_rfc = 10'd9; thr = 4'd4;
    ifc.ref_gnt_i = 1'b0; ifc.bk_idle_arr_i = '1; ifc.bk_req_any_i = 1'b0;
    auto_gnt = 1'b1; m_req_age = 0; m_done_at = -1;

    // opportunistic refresh + tRFC timing (grant lands at cycle 102)
    do_reset();
    chk("rst_block", 16'(ifc.ref_block_o), 16'd0);
    chk("rst_pend",  16'(pend), 16'd0);
    run_to(100); chk("opp_pend100", 16'(pend), 16'd1);
    run_to(101); chk("opp_req101",  16'(ifc.ref_req_o), 16'd1);
    run_to(103); chk("opp_pend_after_gnt", 16'(pend), 16'd0);
    run_to(111); chk("rfc_nodone111", 16'(ifc.ref_done_o), 16'd0);
    run_to(112); chk("rfc_done112",   16'(ifc.ref_done_o), 16'd1);
    run_to(113); chk("rfc_block113",  16'(ifc.ref_block_o), 16'd0);

    // urgent drain: ticks at 9 and 19, banks idle from cycle 24
    t_refi = 16'd9; thr = 4'd2; ifc.bk_req_any_i = 1'b1; ifc.bk_idle_arr_i = '0;
    do_reset();
    run_to(20); chk("urg_pend20",  16'(pend), 16'd2);
    run_to(21); chk("urg_block21", 16'(ifc.ref_block_o), 16'd1);
    run_to(24); chk("urg_noreq24", 16'(ifc.ref_req_o), 16'd0);
    ifc.bk_idle_arr_i = '1;
    run_to(25); chk("urg_req25",   16'(ifc.ref_req_o), 16'd1);
    run_to(45);

    // saturation: ticks every 4 cycles, 9th at cycle 35
    t_refi = 16'd3; thr = 4'd8; ifc.bk_idle_arr_i = '0; auto_gnt = 1'b0;
    do_reset();
    run_to(32); chk("sat_ovf0_32", 16'(ovf), 16'd0);
    run_to(36); chk("sat_pend36", 16'(pend), 16'd8);
    chk("sat_ovf36", 16'(ovf), 16'd1);
    ifc.bk_idle_arr_i = '1; auto_gnt = 1'b1;
    run_to(80); chk("sat_ovf_sticky", 16'(ovf), 16'd1);

    // simultaneous tick+grant at pend=3, stray IDLE grant, reset mid-RFC
    t_refi = 16'd9; thr = 4'd8; t_rfc = 10'd9; ifc.bk_idle_arr_i = '0;
    ifc.bk_req_any_i = 1'b1; auto_gnt = 1'b0;
    do_reset();
    run_to(30); chk("sim_pend30", 16'(pend), 16'd3);
    run_to(32); ifc.ref_gnt_i = 1'b1; step(); ifc.ref_gnt_i = 1'b0;
    chk("sim_idle_gnt", 16'(pend), 16'd3);
    run_to(36); ifc.bk_idle_arr_i = '1; ifc.bk_req_any_i = 1'b0;
    run_to(37); chk("sim_req37", 16'(ifc.ref_req_o), 16'd1);
    run_to(39); ifc.ref_gnt_i = 1'b1; step(); ifc.ref_gnt_i = 1'b0;
    chk("sim_pend40", 16'(pend), 16'd3);
    run_to(43); rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_block", 16'(ifc.ref_block_o), 16'd0);
    chk("mid_rst_done",  16'(ifc.ref_done_o),  16'd0);
    chk("mid_rst_pend",  16'(pend), 16'd0);
    for (int i = 0; i < 12; i++) step();

    // randomized traffic against the model
    t_refi = 16'($urandom_range(2, 12)); t_rfc = 10'($urandom_range(0, 6));
    thr = 4'($urandom_range(1, 8));
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step();
      rst = ($urandom_range(0, 249) == 0);
      en  = ($urandom_range(0, 7) != 0);
      ifc.bk_req_any_i = $urandom_range(0, 1) == 1;
      ifc.bk_idle_arr_i = '1;
      if ($urandom_range(0, 2) == 0) ifc.bk_idle_arr_i[$urandom_range(0, 15)] = 1'b0;
      if (m_ph == PH_REQ) ifc.ref_gnt_i = ($urandom_range(0, 2) == 0);
      else                ifc.ref_gnt_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) t_refi = 16'($urandom_range(2, 12));
      if ($urandom_range(0, 49) == 0) t_rfc  = 10'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) thr    = 4'($urandom_range(1, 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
